// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer mode/command sequencer:
// mode encoding, key indices in arbitration priority order, default timing
// constants and the release-event arbiter.
package countdown_pkg;

    // Default timing for a 50 MHz clkin: 20 ms debounce, 1 s countdown tick
    localparam int DEB_CYCLES_DEFAULT  = 1000000;
    localparam int TICK_CYCLES_DEFAULT = 50000000;

    // Operating modes, encoded as seen on the mode output
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_SET   = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_ALARM = 2'd3
    } mode_t;

    // Key indices; a lower index wins when several keys release together
    localparam int NUM_KEYS = 5;
    localparam int KEY_E    = 0;
    localparam int KEY_U    = 1;
    localparam int KEY_D    = 2;
    localparam int KEY_R    = 3;
    localparam int KEY_L    = 4;

    // Command produced by the arbiter for the mode FSM
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ENTER,
        CMD_UP,
        CMD_DOWN,
        CMD_RIGHT,
        CMD_LEFT
    } cmd_t;

    // Pick the single highest-priority release event; the rest are dropped
    function automatic cmd_t arbitrate(input logic [NUM_KEYS-1:0] rel);
        cmd_t c;
        c = CMD_NONE;
        if (rel[KEY_E])
            c = CMD_ENTER;
        else if (rel[KEY_U])
            c = CMD_UP;
        else if (rel[KEY_D])
            c = CMD_DOWN;
        else if (rel[KEY_R])
            c = CMD_RIGHT;
        else if (rel[KEY_L])
            c = CMD_LEFT;
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchronizer, stable-level debouncer and
// release (stable 0->1) edge detector. level is the debounced key state
// (1 = released); rel_p is high for the one cycle after level rises.
module key_debounce
    import countdown_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clkin,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic rel_p
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          level_d;

    // Bring the asynchronous key pin into the clkin domain; resets to released
    always_ff @(posedge clkin or posedge rst) begin
        if (rst)
            sync_q <= 2'b11;
        else
            sync_q <= {sync_q[0], key_n};
    end

    // Accept a new level only after it has disagreed with the stable one for DEB_CYCLES cycles
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (sync_q[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Remember last cycle's stable level so a rising edge can be seen
    always_ff @(posedge clkin or posedge rst) begin
        if (rst)
            level_d <= 1'b1;
        else
            level_d <= level;
    end

    assign rel_p = level & ~level_d;

endmodule

// File: rtl/countdown_mode_ctrl.sv
// Mode and command sequencer for the 6-digit countdown timer. Debounces the
// five keys, arbitrates their release events, runs the IDLE/SET/RUN/ALARM
// mode FSM and emits single-cycle edit/tick commands to the digit register.
// Optional build macro COUNTDOWN_AUTOREPEAT_EN adds auto-repeat of the up
// and down keys while they are held in SET mode.
module countdown_mode_ctrl
    import countdown_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT,
    parameter int NUM_DIGITS  = 6
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       ke,
    input  logic       ku,
    input  logic       kd,
    input  logic       kl,
    input  logic       kr,
    input  logic       done,
    output logic [1:0] mode,
    output logic [2:0] cursor,
    output logic       inc_p,
    output logic       dec_p,
    output logic       tick_p,
    output logic       clr,
    output logic       msg,
    output logic       alarm
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [2:0]    CURSOR_MAX = 3'(NUM_DIGITS);

    mode_t                state;
    logic [PW-1:0]        presc;
    logic [NUM_KEYS-1:0]  key_n;
    logic [NUM_KEYS-1:0]  key_level;
    logic [NUM_KEYS-1:0]  key_rel;
    logic [NUM_KEYS-1:0]  rel_eff;
    logic                 rpt_up;
    logic                 rpt_dn;
    cmd_t                 cmd;

    assign key_n[KEY_E] = ke;
    assign key_n[KEY_U] = ku;
    assign key_n[KEY_D] = kd;
    assign key_n[KEY_R] = kr;
    assign key_n[KEY_L] = kl;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clkin (clkin),
            .rst   (rst),
            .key_n (key_n[g]),
            .level (key_level[g]),
            .rel_p (key_rel[g])
        );
    end

`ifdef COUNTDOWN_AUTOREPEAT_EN
    localparam int RPT_FIRST  = 8 * DEB_CYCLES;
    localparam int RPT_PERIOD = 2 * DEB_CYCLES;
    localparam int RW         = $clog2(RPT_FIRST);
    localparam logic [RW-1:0] RPT_LAST   = RW'(RPT_FIRST - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(RPT_FIRST - RPT_PERIOD);

    logic [RW-1:0] rpt_cnt [2];
    logic [1:0]    rpt_fire;
    logic [1:0]    rpt_fired;
    logic          unused_levels;

    // A repeat fires when up/down has been held low in SET long enough
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 2; i++)
            rpt_fire[i] = (state == MODE_SET) && !key_level[KEY_U + i] && (rpt_cnt[i] == RPT_LAST);
    end

    // Hold-time counters for up/down; after the first repeat they reload to give the shorter repeat period
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rpt_cnt[i]   <= '0;
                rpt_fired[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state != MODE_SET || key_level[KEY_U + i])
                    rpt_cnt[i] <= '0;
                else if (rpt_fire[i])
                    rpt_cnt[i] <= RPT_RELOAD;
                else
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;

                if (key_level[KEY_U + i])
                    rpt_fired[i] <= 1'b0;
                else if (rpt_fire[i])
                    rpt_fired[i] <= 1'b1;
            end
        end
    end

    // A key that has already auto-repeated does not also act on its release
    always_comb begin
        rel_eff        = key_rel;
        rel_eff[KEY_U] = key_rel[KEY_U] & ~rpt_fired[0];
        rel_eff[KEY_D] = key_rel[KEY_D] & ~rpt_fired[1];
    end

    assign rpt_up        = rpt_fire[0];
    assign rpt_dn        = rpt_fire[1];
    assign unused_levels = ^{key_level[KEY_E], key_level[KEY_R], key_level[KEY_L]};
`else
    logic unused_levels;

    // Only release events drive commands in this build
    always_comb begin
        rel_eff = key_rel;
    end

    assign rpt_up        = 1'b0;
    assign rpt_dn        = 1'b0;
    assign unused_levels = ^key_level;
`endif

    // Reduce simultaneous release events to the single winning command
    always_comb begin
        cmd = arbitrate(rel_eff);
    end

    // Mode FSM with registered command pulses, level outputs, cursor and tick prescaler
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state  <= MODE_IDLE;
            cursor <= 3'd1;
            presc  <= '0;
            inc_p  <= 1'b0;
            dec_p  <= 1'b0;
            tick_p <= 1'b0;
            clr    <= 1'b1;
            msg    <= 1'b0;
            alarm  <= 1'b1;
        end else begin
            inc_p  <= 1'b0;
            dec_p  <= 1'b0;
            tick_p <= 1'b0;
            case (state)
                MODE_IDLE: begin
                    if (cmd == CMD_ENTER) begin
                        state  <= MODE_SET;
                        cursor <= 3'd1;
                        clr    <= 1'b0;
                    end
                end
                MODE_SET: begin
                    case (cmd)
                        CMD_ENTER: begin
                            state <= MODE_RUN;
                            presc <= '0;
                        end
                        CMD_UP:    inc_p <= 1'b1;
                        CMD_DOWN:  dec_p <= 1'b1;
                        CMD_RIGHT: cursor <= (cursor == CURSOR_MAX) ? 3'd1 : cursor + 3'd1;
                        CMD_LEFT:  cursor <= (cursor == 3'd1) ? CURSOR_MAX : cursor - 3'd1;
                        default: begin
                            if (rpt_up)
                                inc_p <= 1'b1;
                            else if (rpt_dn)
                                dec_p <= 1'b1;
                        end
                    endcase
                end
                MODE_RUN: begin
                    if (cmd == CMD_ENTER || done) begin
                        state <= MODE_ALARM;
                        msg   <= 1'b1;
                        alarm <= 1'b0;
                    end else if (presc == PRESC_LAST) begin
                        tick_p <= 1'b1;
                        presc  <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                MODE_ALARM: begin
                    if (cmd == CMD_ENTER) begin
                        state <= MODE_IDLE;
                        clr   <= 1'b1;
                        msg   <= 1'b0;
                        alarm <= 1'b1;
                    end
                end
                default: state <= MODE_IDLE;
            endcase
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_countdown_mode_ctrl.sv
// Self-checking bench for countdown_mode_ctrl with short debounce/tick
// periods. A behavioural model of the key timing and mode rules runs
// alongside the DUT and every cycle's outputs are compared against it;
// directed checks cover the sequencing, edit, arbitration, alarm and
// reset scenarios, then randomized key traffic follows.
// Honours COUNTDOWN_AUTOREPEAT_EN when the DUT is built with it.
module tb_countdown_mode_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 10;
    localparam int ND   = 6;

    localparam int KE = 0;
    localparam int KU = 1;
    localparam int KD = 2;
    localparam int KR = 3;
    localparam int KL = 4;

    logic       clkin  = 1'b0;
    logic       rst    = 1'b0;
    logic [4:0] keys_n = 5'b11111;
    logic       done   = 1'b0;
    logic [1:0] mode;
    logic [2:0] cursor;
    logic       inc_p, dec_p, tick_p, clr, msg, alarm;

    int testsRun  = 0;
    int failCount = 0;
    bit checking  = 1'b0;
    int incCount  = 0;
    int decCount  = 0;
    int tickCount = 0;

    countdown_mode_ctrl #(
        .DEB_CYCLES  (DEB),
        .TICK_CYCLES (TICK),
        .NUM_DIGITS  (ND)
    ) dut (
        .clkin  (clkin),
        .rst    (rst),
        .ke     (keys_n[KE]),
        .ku     (keys_n[KU]),
        .kd     (keys_n[KD]),
        .kl     (keys_n[KL]),
        .kr     (keys_n[KR]),
        .done   (done),
        .mode   (mode),
        .cursor (cursor),
        .inc_p  (inc_p),
        .dec_p  (dec_p),
        .tick_p (tick_p),
        .clr    (clr),
        .msg    (msg),
        .alarm  (alarm)
    );

    always #5 clkin = ~clkin;

    // Reference model state: what the outputs should be this cycle
    int       mMode, mCursor, mPresc;
    bit       mInc, mDec, mTick, mClr, mMsg, mAlarm;
    bit       mStab [5];
    bit       mStabPrev [5];
    int       mRun [5];
    bit [1:0] mPipe [5];
    int       mLow [2];
    bit       mFired [2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mCursor = 1; mPresc = 0;
        mInc = 0; mDec = 0; mTick = 0;
        mClr = 1; mMsg = 0; mAlarm = 1;
        for (int k = 0; k < 5; k++) begin
            mStab[k] = 1; mStabPrev[k] = 1; mRun[k] = 0; mPipe[k] = 2'b11;
        end
        for (int j = 0; j < 2; j++) begin
            mLow[j] = 0; mFired[j] = 0;
        end
    endtask

    // One clock of behaviour, all decisions taken from pre-edge values
    task automatic modelStep();
        bit rel [5];
        bit fire [2];
        int win;
        int cur;
        for (int k = 0; k < 5; k++)
            rel[k] = mStab[k] && !mStabPrev[k];
        fire[0] = 0;
        fire[1] = 0;
`ifdef COUNTDOWN_AUTOREPEAT_EN
        for (int j = 0; j < 2; j++) begin
            cur = (mMode == 1 && !mStab[j + 1]) ? mLow[j] + 1 : 0;
            fire[j] = (cur >= 8 * DEB) && (((cur - 8 * DEB) % (2 * DEB)) == 0);
            if (mFired[j])
                rel[j + 1] = 0;
            mLow[j] = cur;
            mFired[j] = mStab[j + 1] ? 1'b0 : (mFired[j] || fire[j]);
        end
`else
        cur = 0;
`endif
        win = -1;
        for (int k = 0; k < 5; k++)
            if (win < 0 && rel[k])
                win = k;

        mInc = 0; mDec = 0; mTick = 0;
        case (mMode)
            0: if (win == KE) begin mMode = 1; mCursor = 1; end
            1: begin
                if (win == KE) begin mMode = 2; mPresc = 0; end
                else if (win == KU) mInc = 1;
                else if (win == KD) mDec = 1;
                else if (win == KR) mCursor = (mCursor % ND) + 1;
                else if (win == KL) mCursor = ((mCursor + ND - 2) % ND) + 1;
                else if (fire[0]) mInc = 1;
                else if (fire[1]) mDec = 1;
            end
            2: begin
                if (win == KE || done) mMode = 3;
                else if (mPresc == TICK - 1) begin mTick = 1; mPresc = 0; end
                else mPresc++;
            end
            default: if (win == KE) mMode = 0;
        endcase
        mClr   = (mMode == 0);
        mMsg   = (mMode == 3);
        mAlarm = (mMode != 3);

        for (int k = 0; k < 5; k++) begin
            mStabPrev[k] = mStab[k];
            if (mPipe[k][1] != mStab[k]) begin
                mRun[k]++;
                if (mRun[k] == DEB) begin
                    mStab[k] = !mStab[k];
                    mRun[k] = 0;
                end
            end else begin
                mRun[k] = 0;
            end
            mPipe[k] = {mPipe[k][0], keys_n[k]};
        end
    endtask

    always @(posedge clkin or posedge rst) begin
        if (rst)
            modelReset();
        else
            modelStep();
    end

    // Compare DUT to model every cycle, away from the active edge
    always @(negedge clkin) begin
        if (checking) begin
            checkOutput("mode", 32'(mode), 32'(mMode));
            checkOutput("cursor", 32'(cursor), 32'(mCursor));
            checkOutput("outs{inc,dec,tick,clr,msg,alarm}",
                        32'({inc_p, dec_p, tick_p, clr, msg, alarm}),
                        32'({mInc, mDec, mTick, mClr, mMsg, mAlarm}));
            checkOutput("pulse_exclusive", 32'($countones({inc_p, dec_p, tick_p}) <= 1), 32'd1);
            if (inc_p)  incCount++;
            if (dec_p)  decCount++;
            if (tick_p) tickCount++;
        end
    end

    task automatic applyStimulus(input logic [4:0] k, input logic d, input int cycles);
        keys_n = k;
        done   = d;
        repeat (cycles) begin
            @(negedge clkin);
            #1;
        end
    endtask

    task automatic pressKey(input int idx);
        logic [4:0] k;
        k = 5'b11111;
        k[idx] = 1'b0;
        applyStimulus(k, 1'b0, 8);
        applyStimulus(5'b11111, 1'b0, 12);
    endtask

    task automatic waitMode(input logic [1:0] target, input int bound, output bit found);
        found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clkin);
            #1;
            if (mode == target)
                found = 1;
        end
    endtask

    initial begin
        int  base;
        int  n;
        bit  found;
        logic [4:0] k;
        int  hold, gap, r, a, b;

        #1 rst = 1'b1;
        checking = 1'b1;
        applyStimulus(5'b11111, 1'b0, 3);
        checkOutput("reset_mode", 32'(mode), 32'd0);
        checkOutput("reset_cursor", 32'(cursor), 32'd1);
        checkOutput("reset_levels{clr,msg,alarm}", 32'({clr, msg, alarm}), 32'b101);
        checkOutput("reset_pulses", 32'({inc_p, dec_p, tick_p}), 32'd0);
        rst = 1'b0;
        applyStimulus(5'b11111, 1'b0, 3);

        // Sequencing into SET and cursor editing
        pressKey(KE);
        checkOutput("idle_to_set_mode", 32'(mode), 32'd1);
        checkOutput("idle_to_set_cursor", 32'(cursor), 32'd1);
        repeat (3) pressKey(KR);
        checkOutput("cursor_after_3_right", 32'(cursor), 32'd4);
        repeat (4) pressKey(KR);
        checkOutput("cursor_right_wrap", 32'(cursor), 32'd2);
        pressKey(KL);
        checkOutput("cursor_left", 32'(cursor), 32'd1);
        pressKey(KL);
        checkOutput("cursor_left_wrap", 32'(cursor), 32'(ND));

        base = incCount;
        pressKey(KU);
        checkOutput("up_single_inc", 32'(incCount - base), 32'd1);

        // ku and kr released together: ku wins, kr is dropped
        base = incCount;
        applyStimulus(5'b10101, 1'b0, 8);
        applyStimulus(5'b11111, 1'b0, 12);
        checkOutput("arb_inc_count", 32'(incCount - base), 32'd1);
        checkOutput("arb_cursor_kept", 32'(cursor), 32'(ND));

        // A 3-cycle bounce must not register
        base = decCount;
        applyStimulus(5'b11011, 1'b0, 3);
        applyStimulus(5'b11111, 1'b0, 12);
        checkOutput("bounce_no_dec", 32'(decCount - base), 32'd0);
        pressKey(KD);
        checkOutput("down_single_dec", 32'(decCount - base), 32'd1);

        // Long up-key hold in SET
        base = incCount;
        applyStimulus(5'b11101, 1'b0, 60);
        applyStimulus(5'b11111, 1'b0, 15);
`ifdef COUNTDOWN_AUTOREPEAT_EN
        checkOutput("hold_up_inc_count", 32'(incCount - base), 32'd4);
`else
        checkOutput("hold_up_inc_count", 32'(incCount - base), 32'd1);
`endif
        checkOutput("hold_up_mode", 32'(mode), 32'd1);

        // Enter RUN and time the first tick
        applyStimulus(5'b11110, 1'b0, 8);
        applyStimulus(5'b11111, 1'b0, 0);
        waitMode(2'd2, 30, found);
        checkOutput("set_to_run", 32'(found), 32'd1);
        n = 0;
        while (n < 50 && !tick_p) begin
            @(negedge clkin);
            #1;
            n++;
        end
        checkOutput("first_tick_cycle", 32'(n), 32'(TICK));

        // done coinciding with the second tick
        repeat (9) begin
            @(negedge clkin);
            #1;
        end
        done = 1'b1;
        @(negedge clkin);
        #1;
        done = 1'b0;
        checkOutput("done_tick_suppressed", 32'(tick_p), 32'd0);
        checkOutput("done_to_alarm", 32'(mode), 32'd3);
        checkOutput("alarm_levels{msg,alarm}", 32'({msg, alarm}), 32'b10);
        pressKey(KE);
        checkOutput("alarm_to_idle", 32'(mode), 32'd0);
        checkOutput("idle_levels{clr,msg,alarm}", 32'({clr, msg, alarm}), 32'b101);

        // Reset in RUN with ke held across it
        pressKey(KE);
        pressKey(KR);
        pressKey(KE);
        checkOutput("rerun_mode", 32'(mode), 32'd2);
        applyStimulus(5'b11110, 1'b0, 8);
        @(posedge clkin);
        #2 rst = 1'b1;
        @(negedge clkin);
        #1;
        checkOutput("midrun_reset_mode", 32'(mode), 32'd0);
        checkOutput("midrun_reset_cursor", 32'(cursor), 32'd1);
        checkOutput("midrun_reset_outs", 32'({inc_p, dec_p, tick_p, clr, msg, alarm}), 32'b000101);
        applyStimulus(5'b11110, 1'b0, 3);
        rst = 1'b0;
        applyStimulus(5'b11110, 1'b0, 20);
        checkOutput("held_ke_no_event", 32'(mode), 32'd0);
        applyStimulus(5'b11111, 1'b0, 12);
        checkOutput("held_ke_release", 32'(mode), 32'd1);

        // Randomized key traffic against the model
        for (int it = 0; it < 250; it++) begin
            k = 5'b11111;
            r = $urandom_range(0, 9);
            if (r < 7) begin
                k[$urandom_range(0, 4)] = 1'b0;
            end else if (r < 9) begin
                a = $urandom_range(0, 4);
                b = $urandom_range(0, 4);
                k[a] = 1'b0;
                k[b] = 1'b0;
            end
            hold = $urandom_range(1, 9);
            gap  = $urandom_range(1, 14);
            applyStimulus(k, ($urandom_range(0, 15) == 0), hold);
            applyStimulus(5'b11111, 1'b0, gap);
        end
        applyStimulus(5'b11111, 1'b0, 5);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
